// File: rtl/pll_rst_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, qualifies lock with timeout and
// retries, and holds the downstream system reset until lock is stable.
module pll_rst_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 4,
  parameter int CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked_in,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       lock_lost,
  output logic       fault,
  output logic [2:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] L_PULSE_END   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TIMEOUT_END = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_STABLE_END  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [2:0]       L_MAX_RETRY   = 3'(MAX_RETRIES);

  state_t           r_state;
  state_t           w_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt;
  logic             r_sync;
  logic             r_locked_s;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_lock_lost;
  logic             r_fault;
  logic [2:0]       r_retry_cnt;
  logic [7:0]       r_lock_loss_cnt;
  logic             w_lock_lost;
  logic [2:0]       w_retry_cnt;
  logic [7:0]       w_lock_loss_cnt;

  always_comb begin
    w_state         = r_state;
    w_cnt           = r_cnt + 1'b1;
    w_lock_lost     = 1'b0;
    w_retry_cnt     = r_retry_cnt;
    w_lock_loss_cnt = r_lock_loss_cnt;
    case (r_state)
      S_PLL_RESET: begin
        if (r_cnt == L_PULSE_END) begin
          w_state = S_WAIT_LOCK;
          w_cnt   = '0;
        end
      end
      S_WAIT_LOCK: begin
        // lock wins over a coincident timeout
        if (r_locked_s) begin
          w_state = S_STABLE;
          w_cnt   = '0;
        end else if (r_cnt == L_TIMEOUT_END) begin
          w_retry_cnt = r_retry_cnt + 3'd1;
          w_cnt       = '0;
          if (r_retry_cnt + 3'd1 == L_MAX_RETRY) w_state = S_FAULT;
          else w_state = S_PLL_RESET;
        end
      end
      S_STABLE: begin
        if (!r_locked_s) begin
          w_state = S_WAIT_LOCK;
          w_cnt   = '0;
        end else if (r_cnt == L_STABLE_END) begin
          w_state = S_RUN;
          w_cnt   = '0;
        end
      end
      S_RUN: begin
        w_cnt = '0;
        if (!r_locked_s) begin
          w_state     = S_PLL_RESET;
          w_lock_lost = 1'b1;
          w_retry_cnt = 3'd0;
          if (r_lock_loss_cnt != 8'hFF)
            w_lock_loss_cnt = r_lock_loss_cnt + 8'd1;
        end
      end
      S_FAULT: begin
        w_cnt = '0;
      end
      default: begin
        w_state = S_PLL_RESET;
        w_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync          <= 1'b0;
      r_locked_s      <= 1'b0;
      r_state         <= S_PLL_RESET;
      r_cnt           <= '0;
      r_pll_rst       <= 1'b1;
      r_sys_rst       <= 1'b1;
      r_lock_lost     <= 1'b0;
      r_fault         <= 1'b0;
      r_retry_cnt     <= 3'd0;
      r_lock_loss_cnt <= 8'd0;
    end else begin
      r_sync          <= locked_in;
      r_locked_s      <= r_sync;
      r_state         <= w_state;
      r_cnt           <= w_cnt;
      r_pll_rst       <= (w_state == S_PLL_RESET) || (w_state == S_FAULT);
      r_sys_rst       <= (w_state != S_RUN);
      r_lock_lost     <= w_lock_lost;
      r_fault         <= (w_state == S_FAULT);
      r_retry_cnt     <= w_retry_cnt;
      r_lock_loss_cnt <= w_lock_loss_cnt;
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_rst       = r_sys_rst;
  assign lock_lost     = r_lock_lost;
  assign fault         = r_fault;
  assign retry_cnt     = r_retry_cnt;
  assign lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Scoreboard bench for pll_rst_sequencer with short cycle parameters.
module tb_pll_rst_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked_in = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       lock_lost;
  logic       fault;
  logic [2:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  pll_rst_sequencer #(
    .RST_PULSE_CYCLES(4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES(3),
    .CNT_W(16)
  ) u_dut (
    .refclk(refclk),
    .rst(rst),
    .locked_in(locked_in),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .lock_lost(lock_lost),
    .fault(fault),
    .retry_cnt(retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0: get_sig = pll_rst;
      1: get_sig = sys_rst;
      2: get_sig = fault;
      default: get_sig = lock_lost;
    endcase
  endfunction

  // n = negedges until the signal reads val, -1 on timeout
  task automatic wait_sig(input int sel, input logic val,
                          input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge refclk);
      if (get_sig(sel) === val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    locked_in = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int e;
    rst = 1'b1;
    locked_in = 1'b0;
    tick(3);
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    e = exp_q.pop_front(); checks++;
    if (pll_rst !== e[0]) begin failures++;
      $display("FAIL rst_pll_rst: got %b want %0d", pll_rst, e); end
    e = exp_q.pop_front(); checks++;
    if (sys_rst !== e[0]) begin failures++;
      $display("FAIL rst_sys_rst: got %b want %0d", sys_rst, e); end
    e = exp_q.pop_front(); checks++;
    if (lock_lost !== e[0]) begin failures++;
      $display("FAIL rst_lock_lost: got %b want %0d", lock_lost, e); end
    e = exp_q.pop_front(); checks++;
    if (fault !== e[0]) begin failures++;
      $display("FAIL rst_fault: got %b want %0d", fault, e); end
    e = exp_q.pop_front(); checks++;
    if (retry_cnt !== e[2:0]) begin failures++;
      $display("FAIL rst_retry: got %0d want %0d", retry_cnt, e); end
    e = exp_q.pop_front(); checks++;
    if (lock_loss_cnt !== e[7:0]) begin failures++;
      $display("FAIL rst_loss_cnt: got %0d want %0d", lock_loss_cnt, e); end
  endtask

  task automatic test_normal_lock();
    int n, e;
    do_reset();
    exp_q.push_back(4);
    wait_sig(0, 1'b0, 50, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin failures++;
      $display("FAIL normal_pulse_len: got %0d want %0d", n, e); end
    tick(10);
    locked_in = 1'b1;
    exp_q.push_back(11);
    wait_sig(1, 1'b0, 50, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin failures++;
      $display("FAIL normal_sys_rel: got %0d want %0d", n, e); end
    exp_q.push_back(0); exp_q.push_back(0);
    e = exp_q.pop_front(); checks++;
    if (fault !== e[0]) begin failures++;
      $display("FAIL normal_fault: got %b want %0d", fault, e); end
    e = exp_q.pop_front(); checks++;
    if (retry_cnt !== e[2:0]) begin failures++;
      $display("FAIL normal_retry: got %0d want %0d", retry_cnt, e); end
  endtask

  task automatic test_timeout_retry();
    int n, e;
    do_reset();
    exp_q.push_back(4); exp_q.push_back(20); exp_q.push_back(1);
    exp_q.push_back(4); exp_q.push_back(11); exp_q.push_back(1);
    wait_sig(0, 1'b0, 50, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin failures++;
      $display("FAIL to_pulse1: got %0d want %0d", n, e); end
    wait_sig(0, 1'b1, 50, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin failures++;
      $display("FAIL to_wait_len: got %0d want %0d", n, e); end
    e = exp_q.pop_front(); checks++;
    if (retry_cnt !== e[2:0]) begin failures++;
      $display("FAIL to_retry_after_to: got %0d want %0d", retry_cnt, e); end
    wait_sig(0, 1'b0, 50, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin failures++;
      $display("FAIL to_pulse2: got %0d want %0d", n, e); end
    locked_in = 1'b1;
    wait_sig(1, 1'b0, 50, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin failures++;
      $display("FAIL to_sys_rel: got %0d want %0d", n, e); end
    e = exp_q.pop_front(); checks++;
    if (retry_cnt !== e[2:0]) begin failures++;
      $display("FAIL to_retry_run: got %0d want %0d", retry_cnt, e); end
  endtask

  // entered in RUN with retry_cnt=1 left by the previous scenario
  task automatic test_loss_in_run();
    int n, e;
    locked_in = 1'b0;
    exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(1);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
    wait_sig(3, 1'b1, 10, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin failures++;
      $display("FAIL loss_latency: got %0d want %0d", n, e); end
    e = exp_q.pop_front(); checks++;
    if (sys_rst !== e[0]) begin failures++;
      $display("FAIL loss_sys_rst: got %b want %0d", sys_rst, e); end
    e = exp_q.pop_front(); checks++;
    if (pll_rst !== e[0]) begin failures++;
      $display("FAIL loss_pll_rst: got %b want %0d", pll_rst, e); end
    e = exp_q.pop_front(); checks++;
    if (lock_loss_cnt !== e[7:0]) begin failures++;
      $display("FAIL loss_cnt1: got %0d want %0d", lock_loss_cnt, e); end
    e = exp_q.pop_front(); checks++;
    if (retry_cnt !== e[2:0]) begin failures++;
      $display("FAIL loss_retry_clr: got %0d want %0d", retry_cnt, e); end
    tick(1);
    e = exp_q.pop_front(); checks++;
    if (lock_lost !== e[0]) begin failures++;
      $display("FAIL loss_pulse_width: got %b want %0d", lock_lost, e); end
    for (int k = 2; k <= 260; k++) begin
      locked_in = 1'b1;
      wait_sig(1, 1'b0, 100, n);
      checks++;
      if (n < 0) begin failures++;
        $display("FAIL loss_relock_%0d: got timeout want release", k); end
      locked_in = 1'b0;
      exp_q.push_back(k > 255 ? 255 : k);
      wait_sig(3, 1'b1, 10, n);
      e = exp_q.pop_front(); checks++;
      if (n < 0 || lock_loss_cnt !== e[7:0]) begin failures++;
        $display("FAIL loss_cnt_%0d: got %0d want %0d (wait %0d)",
                 k, lock_loss_cnt, e, n); end
    end
  endtask

  task automatic test_reset_mid_wait();
    int n, e;
    locked_in = 1'b0;
    exp_q.push_back(4); exp_q.push_back(20);
    wait_sig(0, 1'b0, 50, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin failures++;
      $display("FAIL rmw_pulse: got %0d want %0d", n, e); end
    wait_sig(0, 1'b1, 50, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin failures++;
      $display("FAIL rmw_timeout: got %0d want %0d", n, e); end
    wait_sig(0, 1'b0, 50, n);
    tick(12);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(4);
    e = exp_q.pop_front(); checks++;
    if (pll_rst !== e[0]) begin failures++;
      $display("FAIL rmw_pll_rst: got %b want %0d", pll_rst, e); end
    e = exp_q.pop_front(); checks++;
    if (sys_rst !== e[0]) begin failures++;
      $display("FAIL rmw_sys_rst: got %b want %0d", sys_rst, e); end
    e = exp_q.pop_front(); checks++;
    if (retry_cnt !== e[2:0]) begin failures++;
      $display("FAIL rmw_retry: got %0d want %0d", retry_cnt, e); end
    e = exp_q.pop_front(); checks++;
    if (lock_loss_cnt !== e[7:0]) begin failures++;
      $display("FAIL rmw_loss_cnt: got %0d want %0d", lock_loss_cnt, e); end
    e = exp_q.pop_front(); checks++;
    if ({fault, lock_lost} !== e[1:0]) begin failures++;
      $display("FAIL rmw_flags: got %b%b want 00", fault, lock_lost); end
    wait_sig(0, 1'b0, 50, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin failures++;
      $display("FAIL rmw_restart_pulse: got %0d want %0d", n, e); end
  endtask

  task automatic test_glitch_stable();
    int n, e;
    do_reset();
    wait_sig(0, 1'b0, 50, n);
    locked_in = 1'b1;
    tick(8);
    locked_in = 1'b0;
    tick(3);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(11);
    e = exp_q.pop_front(); checks++;
    if (sys_rst !== e[0]) begin failures++;
      $display("FAIL gl_sys_rst_held: got %b want %0d", sys_rst, e); end
    e = exp_q.pop_front(); checks++;
    if (pll_rst !== e[0]) begin failures++;
      $display("FAIL gl_pll_rst: got %b want %0d", pll_rst, e); end
    e = exp_q.pop_front(); checks++;
    if (retry_cnt !== e[2:0]) begin failures++;
      $display("FAIL gl_retry: got %0d want %0d", retry_cnt, e); end
    locked_in = 1'b1;
    wait_sig(1, 1'b0, 50, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin failures++;
      $display("FAIL gl_relock_rel: got %0d want %0d", n, e); end
  endtask

  task automatic test_exhausted();
    int n, e;
    do_reset();
    for (int a = 1; a <= 3; a++) begin
      exp_q.push_back(4); exp_q.push_back(20);
      wait_sig(0, 1'b0, 50, n);
      e = exp_q.pop_front(); checks++;
      if (n !== e) begin failures++;
        $display("FAIL ex_pulse%0d: got %0d want %0d", a, n, e); end
      wait_sig(a == 3 ? 2 : 0, 1'b1, 50, n);
      e = exp_q.pop_front(); checks++;
      if (n !== e) begin failures++;
        $display("FAIL ex_wait%0d: got %0d want %0d", a, n, e); end
    end
    exp_q.push_back(3);
    e = exp_q.pop_front(); checks++;
    if (retry_cnt !== e[2:0]) begin failures++;
      $display("FAIL ex_retry: got %0d want %0d", retry_cnt, e); end
    locked_in = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick(1);
      exp_q.push_back(3'b111);
      e = exp_q.pop_front(); checks++;
      if ({fault, pll_rst, sys_rst} !== e[2:0]) begin failures++;
        $display("FAIL ex_hold_%0d: got %b%b%b want 111",
                 c, fault, pll_rst, sys_rst); end
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    locked_in = 1'b0;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(4);
    e = exp_q.pop_front(); checks++;
    if (fault !== e[0]) begin failures++;
      $display("FAIL ex_fault_clr: got %b want %0d", fault, e); end
    e = exp_q.pop_front(); checks++;
    if (retry_cnt !== e[2:0]) begin failures++;
      $display("FAIL ex_retry_clr: got %0d want %0d", retry_cnt, e); end
    wait_sig(0, 1'b0, 50, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e) begin failures++;
      $display("FAIL ex_restart_pulse: got %0d want %0d", n, e); end
  endtask

  initial begin
    test_reset();
    test_normal_lock();
    test_timeout_retry();
    test_loss_in_run();
    test_reset_mid_wait();
    test_glitch_stable();
    test_exhausted();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
